// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave (spi_escravo) and the team's master.
//   MODO0..MODO3  : SPI mode encodings (CPOL = bit 1, CPHA = bit 0)
//   cpol/cpha     : decode helpers for a 2-bit mode
//   BYTE_LARG     : frame width in bits
//   BYTE_UNDERRUN : byte sent when the holding register is empty at a byte load
//   estado_t      : slave FSM states
package spi_pkg;
  localparam logic [1:0] MODO0 = 2'd0;
  localparam logic [1:0] MODO1 = 2'd1;
  localparam logic [1:0] MODO2 = 2'd2;
  localparam logic [1:0] MODO3 = 2'd3;

  localparam int         BYTE_LARG     = 8;
  localparam logic [7:0] BYTE_UNDERRUN = 8'hFF;

  typedef enum logic {OCIOSO, ATIVO} estado_t;

  function automatic logic cpol(input logic [1:0] modo);
    return modo[1];
  endfunction

  function automatic logic cpha(input logic [1:0] modo);
    return modo[0];
  endfunction
endpackage

// File: rtl/spi_sincronizador.sv
// Multi-flop synchroniser with a registered copy for edge detection.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input pin
//   nivel    : synchronised level
//   sobe     : one-cycle pulse on a synchronised 0->1 transition
//   desce    : one-cycle pulse on a synchronised 1->0 transition
// Pin-to-pulse latency is SINC_ESTAGIOS clk; the pulse is acted on at the
// following edge, giving SINC_ESTAGIOS+1 clk from pin to internal event.
module spi_sincronizador #(
  parameter int   SINC_ESTAGIOS = 2,
  parameter logic VALOR_RESET   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic nivel,
  output logic sobe,
  output logic desce
);
  logic [SINC_ESTAGIOS-1:0] cadeia;
  logic                     anterior;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cadeia   <= {SINC_ESTAGIOS{VALOR_RESET}};
      anterior <= VALOR_RESET;
    end else begin
      cadeia   <= {cadeia[SINC_ESTAGIOS-2:0], din};
      anterior <= cadeia[SINC_ESTAGIOS-1];
    end
  end

  assign nivel = cadeia[SINC_ESTAGIOS-1];
  assign sobe  = nivel & ~anterior;
  assign desce = ~nivel & anterior;
endmodule

// File: rtl/spi_escravo.sv
// SPI slave, fully in the clk domain (pins oversampled), 8-bit MSB-first frames,
// several bytes allowed per chip-select assertion.
//   clk, rst           : system clock, async active-high reset
//   tx_dado/tx_valido  : byte to return on MISO, accepted when tx_pronto=1
//   tx_pronto          : holding register empty
//   rx_dado/rx_valido  : last complete byte; rx_valido pulses 1 clk after update
//   spi_clk/spi_mosi/spi_cs_n : from the master
//   spi_miso           : slave data out (0 while deselected)
// Optional (macro SPI_ESCRAVO_UNDERRUN_EN):
//   tx_underrun        : 1-clk pulse when a byte load finds the holding register empty
//   tx_underrun_flag   : sticky copy, cleared by tx_underrun_limpa
module spi_escravo
  import spi_pkg::*;
#(
  parameter int MODO_SPI      = 0,
  parameter int SINC_ESTAGIOS = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SPI_ESCRAVO_UNDERRUN_EN
  output logic       tx_underrun,
  input  logic       tx_underrun_limpa,
  output logic       tx_underrun_flag,
`endif
  input  logic [7:0] tx_dado,
  input  logic       tx_valido,
  output logic       tx_pronto,
  output logic [7:0] rx_dado,
  output logic       rx_valido,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso
);
  localparam logic [1:0] MODO = MODO_SPI[1:0];
  localparam logic       CPOL = cpol(MODO);
  localparam logic       CPHA = cpha(MODO);

  logic sclk_sobe, sclk_desce, sclk_nivel_unused;
  logic mosi_nivel, mosi_sobe_unused, mosi_desce_unused;
  logic cs_sobe, cs_desce, cs_nivel_unused;

  spi_sincronizador #(.SINC_ESTAGIOS(SINC_ESTAGIOS), .VALOR_RESET(CPOL)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_clk),
    .nivel(sclk_nivel_unused), .sobe(sclk_sobe), .desce(sclk_desce));
  spi_sincronizador #(.SINC_ESTAGIOS(SINC_ESTAGIOS), .VALOR_RESET(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .nivel(mosi_nivel), .sobe(mosi_sobe_unused), .desce(mosi_desce_unused));
  spi_sincronizador #(.SINC_ESTAGIOS(SINC_ESTAGIOS), .VALOR_RESET(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .nivel(cs_nivel_unused), .sobe(cs_sobe), .desce(cs_desce));

  estado_t                estado;
  logic [BYTE_LARG-1:0]   hold, tx_sr, rx_sr, fonte;
  logic                   hold_cheio, rx_pend, carga;
  logic [2:0]             cnt;
  logic                   borda_lider, borda_fim, amostra, aciona;

  // Leading edge leaves the idle level CPOL, trailing edge returns to it.
  assign borda_lider = CPOL ? sclk_desce : sclk_sobe;
  assign borda_fim   = CPOL ? sclk_sobe  : sclk_desce;
  assign amostra     = CPHA ? borda_fim   : borda_lider;
  assign aciona      = CPHA ? borda_lider : borda_fim;

  // Byte load points. CPHA=0: at CS fall, and on the drive edge right after
  // bit 7 was sampled (counter back at 0). CPHA=1: on the first drive edge of
  // each byte only, so CS fall itself does not consume the holding register.
  // A CS rise in the same cycle suppresses any edge-driven load.
  always_comb begin
    carga = 1'b0;
    if (estado == OCIOSO) carga = cs_desce & ~CPHA;
    else                  carga = ~cs_sobe & aciona & (cnt == 3'd0);
  end

  assign fonte     = hold_cheio ? hold : BYTE_UNDERRUN;
  assign tx_pronto = ~hold_cheio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado     <= OCIOSO;
      hold       <= '0;
      hold_cheio <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cnt        <= '0;
      rx_dado    <= '0;
      rx_pend    <= 1'b0;
      rx_valido  <= 1'b0;
      spi_miso   <= 1'b0;
    end else begin
      rx_valido <= rx_pend;
      rx_pend   <= 1'b0;

      // An empty holding register accepts even when a load empties it this cycle.
      if (tx_valido && !hold_cheio) begin
        hold       <= tx_dado;
        hold_cheio <= 1'b1;
      end else if (carga) begin
        hold_cheio <= 1'b0;
      end

      case (estado)
        OCIOSO: begin
          spi_miso <= 1'b0;
          if (cs_desce) begin
            estado <= ATIVO;
            cnt    <= '0;
            rx_sr  <= '0;
            if (carga) begin
              tx_sr    <= fonte;
              spi_miso <= fonte[BYTE_LARG-1];
            end
          end
        end
        ATIVO: begin
          if (cs_sobe) begin
            // Partial byte is dropped; rx_dado keeps the last complete byte.
            estado   <= OCIOSO;
            cnt      <= '0;
            rx_sr    <= '0;
            spi_miso <= 1'b0;
          end else begin
            if (amostra) begin
              rx_sr <= {rx_sr[BYTE_LARG-2:0], mosi_nivel};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                rx_dado <= {rx_sr[BYTE_LARG-2:0], mosi_nivel};
                rx_pend <= 1'b1;
              end
            end
            if (carga) begin
              tx_sr    <= fonte;
              spi_miso <= fonte[BYTE_LARG-1];
            end else if (aciona) begin
              tx_sr    <= {tx_sr[BYTE_LARG-2:0], 1'b0};
              spi_miso <= tx_sr[BYTE_LARG-2];
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

`ifdef SPI_ESCRAVO_UNDERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_underrun      <= 1'b0;
      tx_underrun_flag <= 1'b0;
    end else begin
      tx_underrun <= carga & ~hold_cheio;
      if (carga && !hold_cheio)   tx_underrun_flag <= 1'b1;
      else if (tx_underrun_limpa) tx_underrun_flag <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_spi_escravo.sv
// Bench for spi_escravo: one instance per SPI mode, driven by a behavioural
// master. Expected values come from the frame rules: the slave receives what
// the master sent, and the master receives the preloaded byte or 8'hFF.
module tb_spi_escravo;
  localparam int H = 8;  // spi_clk half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sclk = 4'b1100;  // idle at CPOL per mode
  logic [3:0] mosi = '0, cs_n = 4'hF, miso, tx_valido = '0, tx_pronto, rx_valido;
  logic [7:0] tx_dado [4];
  logic [7:0] rx_dado [4];
`ifdef SPI_ESCRAVO_UNDERRUN_EN
  logic [3:0] tx_underrun, tx_underrun_limpa = '0, tx_underrun_flag;
  int         n_und = 0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_escravo #(.MODO_SPI(g), .SINC_ESTAGIOS(2)) dut (
      .clk(clk), .rst(rst),
`ifdef SPI_ESCRAVO_UNDERRUN_EN
      .tx_underrun(tx_underrun[g]), .tx_underrun_limpa(tx_underrun_limpa[g]),
      .tx_underrun_flag(tx_underrun_flag[g]),
`endif
      .tx_dado(tx_dado[g]), .tx_valido(tx_valido[g]), .tx_pronto(tx_pronto[g]),
      .rx_dado(rx_dado[g]), .rx_valido(rx_valido[g]),
      .spi_clk(sclk[g]), .spi_mosi(mosi[g]), .spi_cs_n(cs_n[g]), .spi_miso(miso[g]));
  end

  int nvec = 0, nerr = 0;
  logic [7:0] rxq[$];
  logic [7:0] ultimo [4];
  logic [7:0] f_mo [4], f_tv [4], f_mi [4];
  bit         f_ld [4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (rx_valido[i]) rxq.push_back(rx_dado[i]);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
    if (tx_underrun[1]) n_und++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic carrega(input int m, input logic [7:0] v);
    chk("tx_pronto_antes", tx_pronto[m], 1'b1);
    tx_dado[m] = v; tx_valido[m] = 1'b1;
    @(negedge clk);
    tx_valido[m] = 1'b0;
    chk("tx_pronto_depois", tx_pronto[m], 1'b0);
    @(negedge clk);
  endtask

  task automatic espera(input int m, input int n, input bit ld, input logic [7:0] v);
    if (ld) begin carrega(m, v); ciclos(n - 2); end
    else ciclos(n);
  endtask

  // One bit from the master's point of view; q is the MISO bit it captures.
  task automatic um_bit(input int m, input logic d, input bit ld, input logic [7:0] v,
                        output logic q);
    logic [1:0] mm;
    mm = 2'(m);
    if (!mm[0]) begin
      mosi[m] = d; espera(m, H, ld, v);
      q = miso[m]; sclk[m] = ~mm[1]; ciclos(H);
      sclk[m] = mm[1];
    end else begin
      sclk[m] = ~mm[1]; ciclos(H / 2);
      mosi[m] = d; ciclos(H / 2);
      q = miso[m]; sclk[m] = mm[1]; espera(m, H, ld, v);
    end
  endtask

  // Frame of n bytes; stops after 'corte' bits (-1: never), optionally by reset.
  task automatic quadro(input int m, input int n, input int corte, input bit com_rst);
    bit   parar = 0;
    int   bits = 0;
    logic q;
    rxq.delete();
    if (f_ld[0]) carrega(m, f_tv[0]);
    cs_n[m] = 1'b0; ciclos(H);
    for (int k = 0; k < n && !parar; k++) begin
      f_mi[k] = '0;
      for (int b = 7; b >= 0 && !parar; b--) begin
        if (bits == corte) parar = 1;
        else begin
          um_bit(m, f_mo[k][b], (b == 4) && (k + 1 < n) && f_ld[k+1], f_tv[(k+1)%4], q);
          f_mi[k][b] = q;
          bits++;
        end
      end
    end
    if (corte >= 0 && bits == corte) parar = 1;
    if (parar && com_rst) begin
      rst = 1'b1;
      return;
    end
    ciclos(H); cs_n[m] = 1'b1; ciclos(2 * H);
    chk("miso_ocioso", miso[m], 1'b0);
  endtask

  // Full frame with checks against the frame rules.
  task automatic executa(input int m, input int n);
    quadro(m, n, -1, 0);
    chk("n_rx_valido", rxq.size(), n);
    for (int k = 0; k < n; k++) begin
      chk("rx_byte", (k < rxq.size()) ? {24'h0, rxq[k]} : 32'hDEAD0000, f_mo[k]);
      chk("miso_byte", f_mi[k], f_ld[k] ? f_tv[k] : 8'hFF);
    end
    chk("tx_pronto_fim", tx_pronto[m], 1'b1);
    ultimo[m] = f_mo[n-1];
  endtask

  task automatic limpa_quadro();
    for (int k = 0; k < 4; k++) begin f_ld[k] = 0; f_mo[k] = '0; f_tv[k] = '0; end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin tx_dado[i] = '0; ultimo[i] = '0; end
    ciclos(3);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx_pronto", tx_pronto[i], 1'b1);
      chk("rst_rx_valido", rx_valido[i], 1'b0);
      chk("rst_rx_dado", rx_dado[i], 8'h00);
      chk("rst_miso", miso[i], 1'b0);
    end
    rst = 1'b0; ciclos(4);

    // Mode 0, preload 3C, send A5
    limpa_quadro(); f_mo[0] = 8'hA5; f_ld[0] = 1; f_tv[0] = 8'h3C;
    executa(0, 1);
    // Mode 3, preload 81, send 7E
    limpa_quadro(); f_mo[0] = 8'h7E; f_ld[0] = 1; f_tv[0] = 8'h81;
    executa(3, 1);
    // Modes 1 and 2: two bytes, second tx loaded during the first byte
    for (int m = 1; m <= 2; m++) begin
      limpa_quadro();
      f_mo[0] = 8'hF0; f_mo[1] = 8'h0F;
      f_ld[0] = 1; f_tv[0] = 8'h11; f_ld[1] = 1; f_tv[1] = 8'h22;
      executa(m, 2);
    end

    // Abort after 5 bits of C3, then a full 5A
    limpa_quadro(); f_mo[0] = 8'hC3;
    quadro(0, 1, 5, 0);
    chk("abort_rx_valido", rxq.size(), 0);
    chk("abort_rx_dado", rx_dado[0], ultimo[0]);
    limpa_quadro(); f_mo[0] = 8'h5A; f_ld[0] = 1; f_tv[0] = 8'h96;
    executa(0, 1);

    // Underrun: nothing loaded, master must see FF
`ifdef SPI_ESCRAVO_UNDERRUN_EN
    n_und = 0;
`endif
    limpa_quadro(); f_mo[0] = 8'h33;
    executa(1, 1);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
    chk("underrun_pulsos", n_und, 1);
    chk("underrun_flag", tx_underrun_flag[1], 1'b1);
    ciclos(5);
    chk("underrun_flag_retido", tx_underrun_flag[1], 1'b1);
    tx_underrun_limpa[1] = 1'b1; @(negedge clk); tx_underrun_limpa[1] = 1'b0;
    chk("underrun_flag_limpo", tx_underrun_flag[1], 1'b0);
`endif

    // Reset at bit 4 of a frame whose MISO is all ones
    limpa_quadro(); f_mo[0] = 8'h6B; f_ld[0] = 1; f_tv[0] = 8'hFF;
    quadro(0, 1, 4, 1);
    #1;
    chk("rstmeio_miso", miso[0], 1'b0);
    chk("rstmeio_rx_dado", rx_dado[0], 8'h00);
    chk("rstmeio_tx_pronto", tx_pronto[0], 1'b1);
    chk("rstmeio_rx_valido", rx_valido[0], 1'b0);
    cs_n[0] = 1'b1; sclk = 4'b1100; mosi = '0;
    ciclos(4); rst = 1'b0; ciclos(4);
    chk("rstmeio_sem_rx", rxq.size(), 0);
    for (int i = 0; i < 4; i++) ultimo[i] = '0;
    limpa_quadro(); f_mo[0] = 8'hE7; f_ld[0] = 1; f_tv[0] = 8'h24;
    executa(0, 1);

    // Randomised frames across all modes
    for (int it = 0; it < 24; it++) begin
      int m, n;
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      limpa_quadro();
      for (int k = 0; k < n; k++) begin
        f_mo[k] = 8'($urandom);
        f_tv[k] = 8'($urandom);
        f_ld[k] = bit'($urandom_range(0, 1));
      end
      executa(m, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
